// File: rtl/rangefinder_sopc_cpu_oci_dct_pkg.sv
// Shared types and constants for the OCI data-compressed-trace sequencer.
package rangefinder_sopc_cpu_oci_dct_pkg;

  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;
  localparam int DCT_ATOMS = 15;
  localparam int FRAME_W   = 36;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ENDED   = 2'd3
  } dct_state_t;

  // Trace RAM word layout: count in the top nibble, two spare bits, then the packed atoms.
  function automatic logic [FRAME_W-1:0] dct_frame_pack(
    input logic [DCT_CNT_W-1:0] cnt,
    input logic [DCT_BUF_W-1:0] atoms
  );
    return {cnt, 2'b00, atoms};
  endfunction

endpackage

// File: rtl/rangefinder_sopc_cpu_oci_dct_outreg.sv
// One-entry valid/ready frame register towards trace RAM; also tracks the RAM write address.
module rangefinder_sopc_cpu_oci_dct_outreg
  import rangefinder_sopc_cpu_oci_dct_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_load_data,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [FRAME_W-1:0] o_data,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_wrapped,
  output logic               o_free
);

  logic               r_valid;
  logic [FRAME_W-1:0] r_data;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wrapped;
  logic               w_hs;

  assign w_hs   = r_valid & i_ready;
  // Free when empty or when the held frame leaves this cycle, so a new frame can reload back-to-back.
  assign o_free = ~r_valid | i_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_addr    <= '0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (&r_addr) r_wrapped <= 1'b1;
      end
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_load_data;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_addr    = r_addr;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/rangefinder_sopc_cpu_oci_dct_ctrl.sv
// DCT trace sequencer: packs 2-bit atoms into 15-atom frames, hands them to trace RAM,
// and runs the end-of-test drain handshake.
module rangefinder_sopc_cpu_oci_dct_ctrl
  import rangefinder_sopc_cpu_oci_dct_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OVF_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_trace_en,
  input  logic                 i_atom_valid,
  input  logic [1:0]           i_atom,
  input  logic                 i_flush_req,
  input  logic                 i_end_req,
  output logic                 o_wr_valid,
  input  logic                 i_wr_ready,
  output logic [FRAME_W-1:0]   o_wr_data,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic                 o_wrapped,
  output logic [DCT_BUF_W-1:0] o_dct_buffer,
  output logic [DCT_CNT_W-1:0] o_dct_count,
  output logic [OVF_W-1:0]     o_ovf_cnt,
  output logic                 o_test_ending,
  output logic                 o_test_has_ended
);

  dct_state_t           r_state;
  logic                 r_test_ending;
  logic                 r_test_has_ended;
  logic [DCT_BUF_W-1:0] r_dct_buffer;
  logic [DCT_CNT_W-1:0] r_dct_count;
  logic                 r_flush_pend;
  logic [OVF_W-1:0]     r_ovf_cnt;

  logic w_free;
  logic w_cnt_zero;
  logic w_cnt_full;
  logic w_collect;
  logic w_flush_want;
  logic w_xfer;
  logic w_accept;
  logic w_drop;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + OVF_W'(1);
  endfunction

  assign w_cnt_zero   = (r_dct_count == '0);
  assign w_cnt_full   = (r_dct_count == DCT_CNT_W'(DCT_ATOMS));
  assign w_collect    = (r_state == ST_COLLECT);
  assign w_flush_want = (i_flush_req | r_flush_pend | (r_state == ST_DRAIN)) & ~w_cnt_zero;
  assign w_xfer       = (w_cnt_full | w_flush_want) & w_free;
  // A full accumulator still takes an atom when its contents leave on the same edge.
  assign w_accept     = w_collect & i_atom_valid & (~w_cnt_full | w_xfer);
  assign w_drop       = w_collect & i_atom_valid & ~w_accept;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_end_req) begin
            r_state       <= ST_DRAIN;
            r_test_ending <= 1'b1;
          end else if (i_trace_en) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (i_end_req) begin
            r_state       <= ST_DRAIN;
            r_test_ending <= 1'b1;
          end else if (!i_trace_en) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_cnt_zero && !o_wr_valid) begin
            r_state          <= ST_ENDED;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b1;
          end
        end
        ST_ENDED: begin
          r_state <= ST_ENDED;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_test_ending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dct_buffer <= '0;
      r_dct_count  <= '0;
      r_flush_pend <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      if (w_xfer) begin
        if (w_accept) begin
          r_dct_buffer <= {{(DCT_BUF_W-2){1'b0}}, i_atom};
          r_dct_count  <= DCT_CNT_W'(1);
        end else begin
          r_dct_buffer <= '0;
          r_dct_count  <= '0;
        end
      end else if (w_accept) begin
        r_dct_buffer <= {r_dct_buffer[DCT_BUF_W-3:0], i_atom};
        r_dct_count  <= r_dct_count + DCT_CNT_W'(1);
      end

      // A flush that cannot leave yet is remembered until the next transfer.
      if (w_xfer) begin
        r_flush_pend <= 1'b0;
      end else if (i_flush_req && !w_cnt_zero) begin
        r_flush_pend <= 1'b1;
      end

      if (w_drop) r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end
  end

  rangefinder_sopc_cpu_oci_dct_outreg #(
    .ADDR_W (ADDR_W)
  ) u_outreg (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_xfer),
    .i_load_data (dct_frame_pack(r_dct_count, r_dct_buffer)),
    .i_ready     (i_wr_ready),
    .o_valid     (o_wr_valid),
    .o_data      (o_wr_data),
    .o_addr      (o_wr_addr),
    .o_wrapped   (o_wrapped),
    .o_free      (w_free)
  );

  assign o_dct_buffer     = r_dct_buffer;
  assign o_dct_count      = r_dct_count;
  assign o_ovf_cnt        = r_ovf_cnt;
  assign o_test_ending    = r_test_ending;
  assign o_test_has_ended = r_test_has_ended;

endmodule

// File: tb/tb_rangefinder_sopc_cpu_oci_dct_ctrl.sv
// Directed bench for the DCT trace sequencer (ADDR_W=2 so address wrap is reachable).
module tb_rangefinder_sopc_cpu_oci_dct_ctrl;

  localparam int ADDR_W = 2;
  localparam int OVF_W  = 8;

  logic              clk;
  logic              reset;
  logic              trace_en;
  logic              atom_valid;
  logic [1:0]        atom;
  logic              flush_req;
  logic              end_req;
  logic              wr_valid;
  logic              wr_ready;
  logic [35:0]       wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wrapped;
  logic [29:0]       dct_buffer;
  logic [3:0]        dct_count;
  logic [OVF_W-1:0]  ovf_cnt;
  logic              test_ending;
  logic              test_has_ended;

  int n_vec = 0;
  int n_err = 0;

  rangefinder_sopc_cpu_oci_dct_ctrl #(
    .ADDR_W (ADDR_W),
    .OVF_W  (OVF_W)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_trace_en       (trace_en),
    .i_atom_valid     (atom_valid),
    .i_atom           (atom),
    .i_flush_req      (flush_req),
    .i_end_req        (end_req),
    .o_wr_valid       (wr_valid),
    .i_wr_ready       (wr_ready),
    .o_wr_data        (wr_data),
    .o_wr_addr        (wr_addr),
    .o_wrapped        (wrapped),
    .o_dct_buffer     (dct_buffer),
    .o_dct_count      (dct_count),
    .o_ovf_cnt        (ovf_cnt),
    .o_test_ending    (test_ending),
    .o_test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      atom_valid = 1'b1;
      atom       = a;
      tick();
    end
    atom_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b0; atom_valid = 1'b0; atom = 2'b00;
    flush_req = 1'b0; end_req = 1'b0; wr_ready = 1'b0;
    tick(); tick();
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_count", dct_count, 0);
    chk("rst_flags", {wrapped, test_ending, test_has_ended}, 0);
    reset = 1'b0;

    // Full frame of 2'b01 atoms
    trace_en = 1'b1; wr_ready = 1'b1;
    tick();
    push(2'b01, 15);
    chk("t1_count15", dct_count, 15);
    chk("t1_buffer", dct_buffer, 30'h15555555);
    chk("t1_not_yet_valid", wr_valid, 0);
    tick();
    chk("t1_valid", wr_valid, 1);
    chk("t1_data", wr_data, 36'hF_1555_5555);
    chk("t1_addr0", wr_addr, 0);
    chk("t1_count0", dct_count, 0);
    tick();
    chk("t1_valid_drop", wr_valid, 0);
    chk("t1_addr1", wr_addr, 1);

    // Partial frame via flush, then flush with empty accumulator
    push(2'd3, 1); push(2'd2, 1); push(2'd1, 1);
    chk("t2_count3", dct_count, 3);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("t2_valid", wr_valid, 1);
    chk("t2_data", wr_data, 36'h3_0000_0039);
    chk("t2_addr", wr_addr, 1);
    chk("t2_count0", dct_count, 0);
    tick();
    chk("t2_addr2", wr_addr, 2);
    flush_req = 1'b1; tick(); flush_req = 1'b0; tick();
    chk("t2_empty_flush_valid", wr_valid, 0);
    chk("t2_empty_flush_addr", wr_addr, 2);

    // Backpressure: frame held, accumulator fills, overflow atom dropped
    wr_ready = 1'b0;
    push(2'b10, 15);
    push(2'b11, 1);
    chk("t3_frame1_valid", wr_valid, 1);
    chk("t3_frame1_data", wr_data, 36'hF_2AAA_AAAA);
    chk("t3_count1", dct_count, 1);
    push(2'b11, 14);
    chk("t3_count15", dct_count, 15);
    push(2'b01, 1);
    chk("t3_ovf", ovf_cnt, 1);
    chk("t3_buffer_kept", dct_buffer, 30'h3FFFFFFF);
    chk("t3_frame1_held", wr_data, 36'hF_2AAA_AAAA);
    chk("t3_addr_held", wr_addr, 2);
    wr_ready = 1'b1;
    tick();
    chk("t3_frame2_valid", wr_valid, 1);
    chk("t3_frame2_data", wr_data, 36'hF_3FFF_FFFF);
    chk("t3_addr3", wr_addr, 3);
    chk("t3_count0", dct_count, 0);
    tick();
    chk("t3_drained", wr_valid, 0);

    // Address wrap over five single-atom frames
    do_reset();
    chk("t4_reset_addr", wr_addr, 0);
    for (int k = 0; k < 5; k++) begin
      push(2'b01, 1);
      flush_req = 1'b1; tick(); flush_req = 1'b0;
      chk("t4_valid", wr_valid, 1);
      chk("t4_addr", wr_addr, k % 4);
      chk("t4_data", wr_data, 36'h1_0000_0001);
      chk("t4_wrapped_before", wrapped, (k >= 4) ? 1 : 0);
      tick();
      chk("t4_wrapped_after", wrapped, (k >= 3) ? 1 : 0);
    end

    // End request with everything empty: one cycle of test_ending
    do_reset();
    end_req = 1'b1; tick(); end_req = 1'b0;
    chk("t5e_ending", {test_ending, test_has_ended}, 2'b10);
    tick();
    chk("t5e_ended", {test_ending, test_has_ended}, 2'b01);
    tick();
    chk("t5e_sticky", {test_ending, test_has_ended}, 2'b01);

    // End request with 5 atoms and a slow trace RAM
    do_reset();
    wr_ready = 1'b0;
    push(2'b01, 5);
    chk("t5_count5", dct_count, 5);
    end_req = 1'b1; tick(); end_req = 1'b0;
    chk("t5_ending", test_ending, 1);
    tick();
    chk("t5_frame_valid", wr_valid, 1);
    chk("t5_frame_data", wr_data, 36'h5_0000_0155);
    tick(); tick();
    chk("t5_still_ending", {test_ending, wr_valid, test_has_ended}, 3'b110);
    wr_ready = 1'b1;
    tick();
    chk("t5_hs_addr", wr_addr, 1);
    chk("t5_hs_valid", wr_valid, 0);
    tick();
    chk("t5_ended", {test_ending, test_has_ended}, 2'b01);
    end_req = 1'b1;
    push(2'b10, 3);
    end_req = 1'b0;
    chk("t5_ignored_count", dct_count, 0);
    chk("t5_ignored_ovf", ovf_cnt, 0);
    chk("t5_ignored_flags", {wr_valid, test_ending, test_has_ended}, 3'b001);

    // Asynchronous reset with a held frame and a partial accumulator
    do_reset();
    wr_ready = 1'b0;
    push(2'b01, 15);
    push(2'b10, 7);
    chk("t6_count7", dct_count, 7);
    chk("t6_buffer", dct_buffer, 30'h2AAA);
    chk("t6_valid", wr_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", wr_valid, 0);
    chk("t6_async_data", wr_data, 0);
    chk("t6_async_count", dct_count, 0);
    chk("t6_async_buffer", dct_buffer, 0);
    chk("t6_async_misc", {wr_addr, ovf_cnt, wrapped, test_ending, test_has_ended}, 0);
    tick();
    reset = 1'b0;
    tick();
    wr_ready = 1'b1;
    push(2'b11, 15);
    chk("t6_after_count", dct_count, 15);
    tick();
    chk("t6_after_valid", wr_valid, 1);
    chk("t6_after_data", wr_data, 36'hF_3FFF_FFFF);
    chk("t6_after_addr", wr_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
